// File: rtl/writeback_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : writeback_arb                                                    |
// | Purpose : Merges the in-order pipeline result with NUM_ACH buffered,       |
// |           round-robin arbitrated completion channels onto the regfile      |
// |           write port. Optional macro WB_X0_FILTER_EN drops x0 writes.      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module writeback_arb #(
    parameter int XLEN     = 32,
    parameter int NUM_ACH  = 2,
    parameter int FIFO_DEP = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    stall_i,
    input  logic                    rd_we_i,
    input  logic [4:0]              rd_addr_i,
    input  logic [XLEN-1:0]         rd_data_i,
    input  logic [NUM_ACH-1:0]      ach_valid_i,
    output logic [NUM_ACH-1:0]      ach_ready_o,
    input  logic [5*NUM_ACH-1:0]    ach_rd_addr_i,
    input  logic [XLEN*NUM_ACH-1:0] ach_rd_data_i,
    output logic                    rd_we_o,
    output logic [4:0]              rd_addr_o,
    output logic [XLEN-1:0]         rd_data_o,
    output logic                    busy_o
);

    localparam int AW = $clog2(FIFO_DEP);
    localparam int RW = (NUM_ACH > 1) ? $clog2(NUM_ACH) : 1;
    localparam int EW = 5 + XLEN;

    logic [NUM_ACH-1:0] empty;
    logic [NUM_ACH-1:0] full;
    logic [NUM_ACH-1:0] push;
    logic [NUM_ACH-1:0] pop;
    logic [NUM_ACH-1:0] nonempty_d;
    logic [EW-1:0]      head [NUM_ACH];

    logic               rd_we_q,   rd_we_d;
    logic [4:0]         rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]    rd_data_q, rd_data_d;
    logic               busy_q,    busy_d;
    logic [RW-1:0]      rr_q,      rr_d;

    logic               gnt_valid;
    logic [RW-1:0]      gnt_idx;
    logic [RW-1:0]      rr_nxt;
    logic               sel_v;
    logic [4:0]         sel_a;
    logic [XLEN-1:0]    sel_d;

    genvar k;
    generate
        for (k = 0; k < NUM_ACH; k++) begin : g_ch
            logic [AW:0]   wptr_q, wptr_d;
            logic [AW:0]   rptr_q, rptr_d;
            logic [EW-1:0] mem_q [FIFO_DEP];

            // Full/empty come from registered pointers only: a pop never frees a slot for a same-cycle push.
            assign empty[k]      = (wptr_q == rptr_q);
            assign full[k]       = (wptr_q[AW] != rptr_q[AW]) &&
                                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
            assign push[k]       = ach_valid_i[k] & ~full[k];
            assign wptr_d        = wptr_q + {{AW{1'b0}}, push[k]};
            assign rptr_d        = rptr_q + {{AW{1'b0}}, pop[k]};
            assign nonempty_d[k] = (wptr_d != rptr_d);
            assign head[k]       = mem_q[rptr_q[AW-1:0]];

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    wptr_q <= '0;
                    rptr_q <= '0;
                end else begin
                    wptr_q <= wptr_d;
                    rptr_q <= rptr_d;
                end
            end

            always_ff @(posedge clk_i) begin
                if (push[k]) begin
                    mem_q[wptr_q[AW-1:0]] <= {ach_rd_addr_i[5*k +: 5],
                                              ach_rd_data_i[XLEN*k +: XLEN]};
                end
            end
        end
    endgenerate

    // Scan offsets downward so the nearest non-empty channel at/after rr_q wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int o = NUM_ACH - 1; o >= 0; o--) begin
            if (!empty[(int'(rr_q) + o) % NUM_ACH]) begin
                gnt_valid = 1'b1;
                gnt_idx   = RW'((int'(rr_q) + o) % NUM_ACH);
            end
        end
    end

    assign rr_nxt = (gnt_idx == RW'(NUM_ACH - 1)) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        pop = '0;
        if (!stall_i && !rd_we_i && gnt_valid) begin
            pop[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        rd_we_d   = rd_we_q;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        rr_d      = rr_q;
        sel_v     = 1'b0;
        sel_a     = '0;
        sel_d     = '0;
        if (!stall_i) begin
            if (rd_we_i) begin
                sel_v = 1'b1;
                sel_a = rd_addr_i;
                sel_d = rd_data_i;
            end else if (gnt_valid) begin
                sel_v          = 1'b1;
                {sel_a, sel_d} = head[gnt_idx];
                rr_d           = rr_nxt;
            end
            rd_we_d = 1'b0;
            if (sel_v) begin
`ifdef WB_X0_FILTER_EN
                if (sel_a != 5'd0) begin
                    rd_we_d   = 1'b1;
                    rd_addr_d = sel_a;
                    rd_data_d = sel_d;
                end
`else
                rd_we_d   = 1'b1;
                rd_addr_d = sel_a;
                rd_data_d = sel_d;
`endif
            end
        end
    end

    assign busy_d = |nonempty_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_we_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            busy_q    <= 1'b0;
            rr_q      <= '0;
        end else begin
            rd_we_q   <= rd_we_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            busy_q    <= busy_d;
            rr_q      <= rr_d;
        end
    end

    assign ach_ready_o = ~full;
    assign rd_we_o     = rd_we_q;
    assign rd_addr_o   = rd_addr_q;
    assign rd_data_o   = rd_data_q;
    assign busy_o      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_writeback_arb                                                 |
// | Purpose : Directed bench for writeback_arb with a queue-based reference.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_writeback_arb;

    localparam int XLEN     = 32;
    localparam int NUM_ACH  = 2;
    localparam int FIFO_DEP = 4;

    typedef struct packed {
        logic [4:0]      a;
        logic [XLEN-1:0] d;
    } ent_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    stall;
    logic                    rd_we;
    logic [4:0]              rd_addr;
    logic [XLEN-1:0]         rd_data;
    logic [NUM_ACH-1:0]      ach_valid;
    logic [NUM_ACH-1:0]      ach_ready;
    logic [5*NUM_ACH-1:0]    ach_addr;
    logic [XLEN*NUM_ACH-1:0] ach_data;
    logic                    we_o;
    logic [4:0]              addr_o;
    logic [XLEN-1:0]         data_o;
    logic                    busy_o;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    writeback_arb #(.XLEN(XLEN), .NUM_ACH(NUM_ACH), .FIFO_DEP(FIFO_DEP)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .stall_i       (stall),
        .rd_we_i       (rd_we),
        .rd_addr_i     (rd_addr),
        .rd_data_i     (rd_data),
        .ach_valid_i   (ach_valid),
        .ach_ready_o   (ach_ready),
        .ach_rd_addr_i (ach_addr),
        .ach_rd_data_i (ach_data),
        .rd_we_o       (we_o),
        .rd_addr_o     (addr_o),
        .rd_data_o     (data_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    // Reference model: per-channel queues and a plain integer RR pointer.
    ent_t            mq [NUM_ACH][$];
    int              m_rr   = 0;
    logic            m_we   = 1'b0;
    logic [4:0]      m_addr = '0;
    logic [XLEN-1:0] m_data = '0;
    logic            m_busy = 1'b0;
    bit              m_push [NUM_ACH];
    int              m_g;
    ent_t            m_e;

    task automatic m_apply(input logic [4:0] a, input logic [XLEN-1:0] d);
`ifdef WB_X0_FILTER_EN
        if (a == 5'd0) begin
            m_we = 1'b0;
        end else begin
            m_we = 1'b1; m_addr = a; m_data = d;
        end
`else
        m_we = 1'b1; m_addr = a; m_data = d;
`endif
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int c = 0; c < NUM_ACH; c++) mq[c].delete();
                m_rr = 0; m_we = 1'b0; m_addr = '0; m_data = '0; m_busy = 1'b0;
            end else begin
                for (int c = 0; c < NUM_ACH; c++)
                    m_push[c] = ach_valid[c] && (mq[c].size() < FIFO_DEP);
                if (!stall) begin
                    if (rd_we) begin
                        m_apply(rd_addr, rd_data);
                    end else begin
                        m_g = -1;
                        for (int o = 0; o < NUM_ACH; o++) begin
                            if (m_g < 0 && mq[(m_rr + o) % NUM_ACH].size() > 0)
                                m_g = (m_rr + o) % NUM_ACH;
                        end
                        if (m_g >= 0) begin
                            m_e  = mq[m_g].pop_front();
                            m_rr = (m_g + 1) % NUM_ACH;
                            m_apply(m_e.a, m_e.d);
                        end else begin
                            m_we = 1'b0;
                        end
                    end
                end
                for (int c = 0; c < NUM_ACH; c++) begin
                    if (m_push[c]) begin
                        m_e.a = ach_addr[5*c +: 5];
                        m_e.d = ach_data[XLEN*c +: XLEN];
                        mq[c].push_back(m_e);
                    end
                end
                m_busy = 1'b0;
                for (int c = 0; c < NUM_ACH; c++) if (mq[c].size() != 0) m_busy = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [NUM_ACH-1:0] m_ready;
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int c = 0; c < NUM_ACH; c++) m_ready[c] = (mq[c].size() < FIFO_DEP);
                check("model_we",    64'(we_o),      64'(m_we));
                check("model_addr",  64'(addr_o),    64'(m_addr));
                check("model_data",  64'(data_o),    64'(m_data));
                check("model_busy",  64'(busy_o),    64'(m_busy));
                check("model_ready", 64'(ach_ready), 64'(m_ready));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_ach(input int c, input logic v, input logic [4:0] a, input logic [XLEN-1:0] d);
        ach_valid[c]          = v;
        ach_addr[5*c +: 5]    = a;
        ach_data[XLEN*c +: XLEN] = d;
    endtask

    task automatic exp_out(input string name, input logic we, input logic [4:0] a, input logic [XLEN-1:0] d);
        check({name, "_we"},   64'(we_o),   64'(we));
        check({name, "_addr"}, 64'(addr_o), 64'(a));
        check({name, "_data"}, 64'(data_o), 64'(d));
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; rd_we = 1'b0; rd_addr = '0; rd_data = '0;
        ach_valid = '0; ach_addr = '0; ach_data = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk_en = 1'b1;
        exp_out("reset", 1'b0, 5'd0, 32'h0);
        check("reset_busy",  64'(busy_o),    64'd0);
        check("reset_ready", 64'(ach_ready), 64'b11);

        // Pipeline path, then queued ach0 entry follows once rd_we_i drops
        rd_we = 1'b1; rd_addr = 5'd5; rd_data = 32'hDEADBEEF;
        set_ach(0, 1'b1, 5'd9, 32'h900);
        tick();
        exp_out("pipe", 1'b1, 5'd5, 32'hDEADBEEF);
        rd_we = 1'b0; set_ach(0, 1'b0, 5'd0, 32'h0);
        tick();
        exp_out("pipe_then_ach0", 1'b1, 5'd9, 32'h900);
        tick();
        check("idle_we", 64'(we_o), 64'd0);

        // Reset mid-stream with 3 entries queued
        rd_we = 1'b1; rd_addr = 5'd6; rd_data = 32'h66;
        tick();
        rd_we = 1'b0; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_ach(0, 1'b1, 5'(20 + i), 32'(32'h200 + i));
            tick();
        end
        set_ach(0, 1'b0, 5'd0, 32'h0);
        check("pre_rst_busy", 64'(busy_o), 64'd1);
        exp_out("pre_rst", 1'b1, 5'd6, 32'h66);
        #2 rst = 1'b1;
        #1 exp_out("async_rst", 1'b0, 5'd0, 32'h0);
        check("async_rst_busy", 64'(busy_o), 64'd0);
        tick();
        rst = 1'b0; stall = 1'b0;
        tick();
        check("post_rst_ready", 64'(ach_ready), 64'b11);
        check("post_rst_busy",  64'(busy_o),    64'd0);

        // Round-robin ordering
        set_ach(0, 1'b1, 5'd1, 32'h11);
        set_ach(1, 1'b1, 5'd3, 32'h33);
        tick();
        set_ach(0, 1'b1, 5'd2, 32'h22);
        set_ach(1, 1'b0, 5'd0, 32'h0);
        tick();
        set_ach(0, 1'b0, 5'd0, 32'h0);
        exp_out("rr0", 1'b1, 5'd1, 32'h11);
        tick();
        exp_out("rr1", 1'b1, 5'd3, 32'h33);
        tick();
        exp_out("rr2", 1'b1, 5'd2, 32'h22);
        tick();
        exp_out("rr_idle", 1'b0, 5'd2, 32'h22);

        // Fill ach1 under stall; fifth push refused
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_ach(1, 1'b1, 5'(10 + i), 32'(32'hA0 + i));
            tick();
            if (i == 3) check("full_ready", 64'(ach_ready), 64'b01);
        end
        set_ach(1, 1'b0, 5'd0, 32'h0);
        exp_out("full_hold", 1'b0, 5'd2, 32'h22);
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_out("drain", 1'b1, 5'(10 + i), 32'(32'hA0 + i));
        end
        tick();
        check("drain_done_we", 64'(we_o), 64'd0);

        // Stall hold with pending channel data
        rd_we = 1'b1; rd_addr = 5'd7; rd_data = 32'h77;
        tick();
        exp_out("stall_pre", 1'b1, 5'd7, 32'h77);
        stall = 1'b1; rd_addr = 5'd8; rd_data = 32'h88;
        set_ach(0, 1'b1, 5'd12, 32'hC);
        for (int i = 0; i < 3; i++) begin
            tick();
            set_ach(0, 1'b0, 5'd0, 32'h0);
            exp_out("stall_hold", 1'b1, 5'd7, 32'h77);
        end
        check("stall_busy", 64'(busy_o), 64'd1);
        stall = 1'b0; rd_we = 1'b0;
        tick();
        exp_out("stall_release", 1'b1, 5'd12, 32'hC);
        tick();

        // x0 writes from pipeline and from a channel
        rd_we = 1'b1; rd_addr = 5'd0; rd_data = 32'h99;
        set_ach(1, 1'b1, 5'd0, 32'h5);
        tick();
        rd_we = 1'b0; set_ach(1, 1'b0, 5'd0, 32'h0);
`ifdef WB_X0_FILTER_EN
        exp_out("x0_pipe", 1'b0, 5'd12, 32'hC);
        tick();
        exp_out("x0_ach", 1'b0, 5'd12, 32'hC);
`else
        exp_out("x0_pipe", 1'b1, 5'd0, 32'h99);
        tick();
        exp_out("x0_ach", 1'b1, 5'd0, 32'h5);
`endif
        check("x0_busy", 64'(busy_o), 64'd0);
        tick();
        check("x0_idle_we", 64'(we_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
